// File: rtl/nb_route_scheduler.sv
// Route sequencer for the North Bridge four-way demux: buffers routed words and
// strobes them one at a time to their target. Optional drop-on-timeout: NB_SCHED_TIMEOUT_EN.
module nb_route_scheduler #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [1:0]                    in_dest,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             route_data,
  output logic [1:0]                    route_select,
  output logic [3:0]                    route_strobe,
  input  logic [3:0]                    tgt_ack,
  output logic                          err_valid,
  output logic [1:0]                    err_dest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              ack;
  logic              expire;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        head_dest;

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign in_ready   = (count != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign fifo_level = count;
  assign head_data  = mem[rd_ptr][DATA_W-1:0];
  assign head_dest  = mem[rd_ptr][DATA_W+1:DATA_W];
  assign ack        = tgt_ack[route_select];
  assign pop        = (state == SEND) && (ack || expire);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_dest, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      route_data   <= '0;
      route_select <= '0;
      route_strobe <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            route_data   <= head_data;
            route_select <= head_dest;
            route_strobe <= 4'(4'b0001 << head_dest);
            state        <= SEND;
          end
        end
        SEND: begin
          if (pop) begin
            route_data   <= '0;
            route_select <= '0;
            route_strobe <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NB_SCHED_TIMEOUT_EN
  logic [7:0] tcnt;

  assign expire = (state == SEND) && (tcnt == 8'(TIMEOUT - 1));

  // Counter is held clear in IDLE, which is equivalent to clearing on SEND entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt      <= '0;
      err_valid <= 1'b0;
      err_dest  <= '0;
    end else begin
      err_valid <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
      end else if (expire && !ack) begin
        err_valid <= 1'b1;
        err_dest  <= route_select;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
`else
  assign expire    = 1'b0;
  assign err_valid = 1'b0;
  assign err_dest  = '0;
`endif

endmodule

// File: doc/nb_route_scheduler.md
# nb_route_scheduler

Sequencing controller for the North Bridge 16-bit four-way routing demultiplexer. It accepts routed words (data plus 2-bit destination) from the upstream bus through a valid/ready handshake and buffers them in a small FIFO. It presents one word at a time on the demux data/select inputs with a one-hot strobe, holding it until the addressed target acknowledges. An optional timeout drops words whose target never responds.

## Interface
Parameters:
- DATA_W, 16, routed word width; matches the demux datapath.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.
- TIMEOUT, 15, maximum SEND cycles waiting for ack before the word is dropped; range 1..255. Used only when NB_SCHED_TIMEOUT_EN is defined.

Ports (one clock, `clk`; reset `rst_n` is synchronous and active-low):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_W  word to route.
- in_dest  in  2  destination port 0..3.
- in_valid  in  1  upstream offers in_data/in_dest.
- in_ready  out  1  FIFO can accept; equals !full, registered count based.
- route_data  out  DATA_W  to demux input_data; 0 when not in SEND.
- route_select  out  2  to demux select; 0 when not in SEND.
- route_strobe  out  4  one-hot valid toward the targets; bit = dest in SEND, else 0.
- tgt_ack  in  4  per-target acknowledge; only bit route_select is honoured in SEND.
- err_valid  out  1  one-cycle pulse when a word is dropped on timeout.
- err_dest  out  2  destination of the dropped word; holds its last value.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: in_valid && in_ready at an edge writes {in_dest, in_data} at the tail.
- A push is accepted only when the FIFO is not full. A pop in the same cycle does not free space for that cycle's push.
- FSM states:
  - IDLE: outputs zeroed. If the FIFO is non-empty, load the head into the output registers and go to SEND.
  - SEND: route_data, route_select and route_strobe are driven from the head entry and held stable.
    - tgt_ack[route_select] = 1: pop the head, go to IDLE.
    - Timeout expiry (enabled): pop the head, pulse err_valid, load err_dest, go to IDLE.
- Acks on non-selected bits, and any ack in IDLE, are ignored.
- Ack and timeout expiry in the same cycle: the ack wins and no error is reported.
- Ordering is strict FIFO. There is no per-destination reordering, so a stalled target blocks all later words (head-of-line blocking by design).
- Pointers wrap modulo FIFO_DEPTH. fifo_level is incremented on push, decremented on pop, and unchanged when both occur.
- Reset values: state IDLE, FIFO empty, fifo_level 0, in_ready 1, route_data 0, route_select 0, route_strobe 0, err_valid 0, err_dest 0, timeout counter 0.
- Reset during SEND discards the in-flight word and all buffered words. Outputs return to their reset values at that edge, and no err_valid is produced.

## Timing
- Latency from push edge E0 (into an empty FIFO, state IDLE) to route_strobe high: strobe is visible after E1, one cycle after the push edge.
- Ack sampled at edge Ek: strobe is low after Ek, with pop at Ek.
- The next word's strobe appears after Ek+1. One IDLE cycle always separates words, so peak throughput is one word per 2 cycles with a same-cycle ack.
- Timeout counter: cleared on entry to SEND and incremented each SEND cycle.
  - Expiry occurs when the counter equals TIMEOUT-1 with no ack. At that edge the word is dropped, and err_valid is high during the following cycle only.
  - Result: a non-responding target holds the strobe for exactly TIMEOUT cycles.
- in_ready reflects occupancy after the previous edge. When the FIFO is full it stays 0 for the whole cycle, even while a pop is occurring.

## Configuration
- NB_SCHED_TIMEOUT_EN:
  - Defined: timeout counter, err_valid and err_dest are active as described above.
  - Undefined: no counter is built, SEND waits indefinitely for ack, err_valid is tied 0 and err_dest is tied 0.

## Test plan
- Single word: push in_data=16'hA5A5, in_dest=2, ack in the 3rd SEND cycle -> route_select=2 and route_strobe=4'b0100 from the cycle after the push edge for 3 cycles; pop leaves fifo_level=0.
- Fill and backpressure: push 5 words with no ack -> in_ready=0 after the 4th push, the 5th push is rejected, and fifo_level=4. Then ack 4 times -> words emerge in push order.
- Wrong-port ack: dest=1, tgt_ack=4'b1000 held -> no pop and strobe stays 4'b0010. Then tgt_ack=4'b0010 -> pop.
- Timeout (macro defined, TIMEOUT=15): dest=3, never ack -> strobe high for exactly 15 cycles, then err_valid=1 for 1 cycle with err_dest=3; the next word starts after one IDLE cycle.
- Ack/timeout collision: ack on the 15th SEND cycle -> pop with err_valid staying 0.
- Reset mid-SEND: rst_n=0 for 1 cycle with 3 words buffered -> all outputs at reset values, fifo_level=0, no err_valid, in_ready=1.
